// File: rtl/dispenser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dispenser_pkg : state encodings and handshake levels for the emit stages    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dispenser_pkg;

  typedef enum logic [1:0] {
    E2_IDLE = 2'b00,
    E2_ON   = 2'b01,
    E2_OFF  = 2'b10,
    E2_ACK  = 2'b11
  } e2_state_t;

  // Request/acknowledge levels shared by the emit1 and emit2 four-phase link.
  localparam logic HS_REQ_ASSERTED = 1'b1;
  localparam logic HS_ACK_ASSERTED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | down_timer : loadable down-counter that holds at zero and flags it          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module down_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/emit2_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | emit2_pulse : dose stage - timed pump pulse, settle, four-phase ack, total  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module emit2_pulse
  import dispenser_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 50,
  parameter int unsigned OFF_CYCLES = 20,
  parameter int unsigned TMR_W      = 16,
  parameter int unsigned TOTAL_W    = 8
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               count2,
  input  logic               abort,
  input  logic               clr_total,
  output logic               count_ACK2,
  output logic               pump_out,
  output logic               busy,
  output logic [TOTAL_W-1:0] dose_total
);

  localparam logic [TMR_W-1:0]   c_on_load   = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]   c_off_load  = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TOTAL_W-1:0] c_total_max = {TOTAL_W{1'b1}};

  e2_state_t          state_q;
  e2_state_t          state_d;
  logic [TOTAL_W-1:0] dose_total_q;
  logic [TOTAL_W-1:0] dose_total_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               tmr_en;
  logic               tmr_zero;
  logic               dose_inc;

  down_timer #(
    .WIDTH (TMR_W)
  ) u_tmr (
    .clk      (clk),
    .RESET    (RESET),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // The timer holds N-1 on entry, so each timed state lasts exactly N cycles.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    dose_inc     = 1'b0;
    case (state_q)
      E2_IDLE: begin
        if ((count2 == HS_REQ_ASSERTED) && !abort) begin
          tmr_load     = 1'b1;
          tmr_load_val = c_on_load;
          state_d      = E2_ON;
        end
      end
      E2_ON: begin
        if (abort) begin
          state_d = E2_IDLE;
        end else if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = c_off_load;
          state_d      = E2_OFF;
        end else begin
          tmr_en = 1'b1;
        end
      end
      E2_OFF: begin
        if (abort) begin
          state_d = E2_IDLE;
        end else if (tmr_zero) begin
          dose_inc = 1'b1;
          state_d  = E2_ACK;
        end else begin
          tmr_en = 1'b1;
        end
      end
      E2_ACK: begin
        if (count2 != HS_REQ_ASSERTED) begin
          state_d = E2_IDLE;
        end
      end
      default: begin
        state_d = E2_IDLE;
      end
    endcase
  end

  // Clear takes priority over a coincident increment.
  always_comb begin
    dose_total_d = dose_total_q;
    if (clr_total) begin
      dose_total_d = '0;
    end else if (dose_inc && (dose_total_q != c_total_max)) begin
      dose_total_d = dose_total_q + TOTAL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q      <= E2_IDLE;
      dose_total_q <= '0;
    end else begin
      state_q      <= state_d;
      dose_total_q <= dose_total_d;
    end
  end

  assign pump_out   = (state_q == E2_ON);
  assign count_ACK2 = (state_q == E2_ACK) ? HS_ACK_ASSERTED : ~HS_ACK_ASSERTED;
  assign busy       = (state_q != E2_IDLE);
  assign dose_total = dose_total_q;

endmodule
`default_nettype wire

// File: tb/tb_emit2_pulse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_emit2_pulse : scoreboard bench for emit2_pulse (3-on / 2-off timing)     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_emit2_pulse;

  logic       clk;
  logic       RESET;
  logic       count2;
  logic       abort;
  logic       clr_total;
  logic       ack_a, pump_a, busy_a;
  logic       ack_b, pump_b, busy_b;
  logic [7:0] total_a;
  logic [1:0] total_b;

  int checks = 0;
  int errors = 0;
  int ea = 0;
  int eb = 0;

  typedef struct {
    int kind;  // 0 = pump pulse, 1 = acknowledge
    int len;
    int off;
    int ta;
    int tb;
  } ev_t;
  ev_t exp_q[$];

  emit2_pulse #(.ON_CYCLES(3), .OFF_CYCLES(2), .TMR_W(4), .TOTAL_W(8)) dut_a (
    .clk(clk), .RESET(RESET), .count2(count2), .abort(abort), .clr_total(clr_total),
    .count_ACK2(ack_a), .pump_out(pump_a), .busy(busy_a), .dose_total(total_a)
  );

  emit2_pulse #(.ON_CYCLES(3), .OFF_CYCLES(2), .TMR_W(4), .TOTAL_W(2)) dut_b (
    .clk(clk), .RESET(RESET), .count2(count2), .abort(abort), .clr_total(clr_total),
    .count_ACK2(ack_b), .pump_out(pump_b), .busy(busy_b), .dose_total(total_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  int pump_len = 0;
  int off_len  = 0;
  int ack_len  = 0;
  int cap_off, cap_a, cap_b;

  task automatic score(input int kind, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d len %0d expected none", kind, len);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == 0) begin
          chk("pulse_len", len, e.len);
        end else begin
          chk("ack_len", len, e.len);
          chk("settle_len", cap_off, e.off);
          chk("total_a_at_ack", cap_a, e.ta);
          chk("total_b_at_ack", cap_b, e.tb);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      pump_len = 0;
      off_len  = 0;
      ack_len  = 0;
    end else begin
      if (pump_a) begin
        pump_len++;
      end else if (pump_len != 0) begin
        score(0, pump_len);
        pump_len = 0;
      end
      if (busy_a && !pump_a && !ack_a) off_len++;
      else if (!busy_a) off_len = 0;
      if (ack_a) begin
        if (ack_len == 0) begin
          cap_off = off_len;
          cap_a   = int'(total_a);
          cap_b   = int'(total_b);
        end
        ack_len++;
      end else if (ack_len != 0) begin
        score(1, ack_len);
        ack_len = 0;
        off_len = 0;
      end
    end
  end

  // emit1 model: holds the request until it sees the ack, drops it 1+extra cycles later.
  task automatic dose(input int hold_extra, input bit clr_coinc);
    int n;
    if (clr_coinc) begin
      ea = 0;
      eb = 0;
    end else begin
      ea = (ea == 255) ? 255 : ea + 1;
      eb = (eb == 3) ? 3 : eb + 1;
    end
    exp_q.push_back('{0, 3, 0, 0, 0});
    exp_q.push_back('{1, 2 + hold_extra, 2, ea, eb});
    count2 = 1'b1;
    if (clr_coinc) begin
      repeat (5) tick();
      clr_total = 1'b1;
      tick();
      clr_total = 1'b0;
    end
    n = 0;
    while (!ack_a && n < 100) begin
      tick();
      n++;
    end
    if (!ack_a) begin
      chk("ack_timeout", 0, 1);
      count2 = 1'b0;
      return;
    end
    repeat (1 + hold_extra) tick();
    count2 = 1'b0;
    n = 0;
    while (busy_a && n < 20) begin
      tick();
      n++;
    end
    chk("idle_after_ack", int'(busy_a), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    count2 = 1'b0;
    abort = 1'b0;
    clr_total = 1'b0;
    #3;
    chk("rst_pump", int'(pump_a), 0);
    chk("rst_ack", int'(ack_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_total", int'(total_a), 0);
    repeat (2) tick();
    RESET = 1'b1;
    tick();

    // Nominal dose
    dose(0, 1'b0);
    chk("nominal_total", int'(total_a), 1);

    // Back-to-back, including one where emit1 holds the request in ACK longer
    dose(0, 1'b0);
    dose(0, 1'b0);
    dose(2, 1'b0);
    chk("b2b_total_a", int'(total_a), 4);
    chk("b2b_total_b", int'(total_b), 3);

    // Fifth dose: narrow counter stays saturated
    dose(0, 1'b0);
    chk("sat_total_b", int'(total_b), 3);

    // Clear coincident with increment
    dose(0, 1'b1);
    chk("clr_total_a", int'(total_a), 0);
    chk("clr_total_b", int'(total_b), 0);

    // Abort in the second ON cycle
    dose(0, 1'b0);
    exp_q.push_back('{0, 2, 0, 0, 0});
    count2 = 1'b1;
    tick();
    tick();
    chk("abort_pre_pump", int'(pump_a), 1);
    abort = 1'b1;
    count2 = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_pump", int'(pump_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_ack", int'(ack_a), 0);
    repeat (8) tick();
    chk("abort_total", int'(total_a), 1);

    // Async reset in the second OFF cycle
    exp_q.push_back('{0, 3, 0, 0, 0});
    count2 = 1'b1;
    tick();
    repeat (4) tick();
    chk("off_pump", int'(pump_a), 0);
    chk("off_busy", int'(busy_a), 1);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_pump_a", int'(pump_a), 0);
    chk("arst_ack_a", int'(ack_a), 0);
    chk("arst_busy_a", int'(busy_a), 0);
    chk("arst_total_a", int'(total_a), 0);
    chk("arst_pump_b", int'(pump_b), 0);
    chk("arst_ack_b", int'(ack_b), 0);
    chk("arst_busy_b", int'(busy_b), 0);
    chk("arst_total_b", int'(total_b), 0);
    count2 = 1'b0;
    ea = 0;
    eb = 0;
    #3;
    RESET = 1'b1;
    tick();
    chk("post_rst_busy", int'(busy_a), 0);
    chk("post_rst_total", int'(total_a), 0);

    dose(0, 1'b0);
    chk("post_rst_dose_total", int'(total_a), 1);

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
